// File: rtl/bp_table_sequencer.sv
// Single-port sequencer for the YAGS predictor tables: init sweep, lookup/update
// arbitration and a small in-order update FIFO that drains when the port is free.
module bp_table_sequencer #(
  parameter int unsigned       IDX_W    = 10,
  parameter int unsigned       DATA_W   = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1),
  parameter int unsigned       DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lk_valid,
  input  logic [IDX_W-1:0]         lk_idx,
  output logic                     lk_grant,
  input  logic                     upd_valid,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic [DATA_W-1:0]        upd_data,
  output logic                     upd_ready,
  input  logic                     flush_req,
  output logic                     busy,
  output logic                     tbl_en,
  output logic                     tbl_we,
  output logic [IDX_W-1:0]         tbl_addr,
  output logic [DATA_W-1:0]        tbl_wdata,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  fifo_idx_q  [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic              full, empty, push, pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign q_count = reset ? '0 : cnt_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    pop       = 1'b0;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    lk_grant  = 1'b0;
    upd_ready = 1'b0;
    busy      = 1'b1;

    if (!reset) begin
      unique case (state_q)
        StInit: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = ptr_q;
          tbl_wdata = INIT_VAL;
          ptr_d     = ptr_q + 1'b1;
          if (flush_req) begin
            ptr_d = '0;
          end else if (ptr_q == LAST_IDX) begin
            state_d = StRun;
          end
        end
        StRun: begin
          busy      = 1'b0;
          upd_ready = !full;
          // A full FIFO takes the port from fetch so updates cannot starve.
          if (full) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = fifo_idx_q[rd_ptr_q];
            tbl_wdata = fifo_data_q[rd_ptr_q];
            pop       = 1'b1;
          end else if (lk_valid) begin
            tbl_en   = 1'b1;
            tbl_addr = lk_idx;
            lk_grant = 1'b1;
          end else if (!empty) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = fifo_idx_q[rd_ptr_q];
            tbl_wdata = fifo_data_q[rd_ptr_q];
            pop       = 1'b1;
          end else if (upd_valid && !flush_req) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = upd_idx;
            tbl_wdata = upd_data;
          end

          // Bypassed updates (empty FIFO, idle port) are never enqueued.
          push = upd_valid && !full && !flush_req && (lk_valid || !empty);

          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
          unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
          endcase

          if (flush_req) begin
            state_d  = StInit;
            ptr_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInit;
      ptr_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= upd_idx;
      fifo_data_q[wr_ptr_q] <= upd_data;
    end
  end

endmodule

// File: doc/bp_table_sequencer.md
Name: bp_table_sequencer

Overview:
- Sequences the single-ported YAGS predictor tables (choice PHT / direction caches) in the RV32I pipeline.
- Runs the post-reset and flush initialization sweep.
- Arbitrates the one table port between fetch-stage lookups and execute-stage updates.
- Buffers updates in a small in-order FIFO when a lookup holds the port.

Parameters:
- IDX_W, 10, table index width; table depth N = 2^IDX_W.
- DATA_W, 2, table entry width (2-bit saturating counter).
- INIT_VAL, 2'b01, value written to every entry during a sweep (weakly not-taken).
- DEPTH, 4, update FIFO depth; must be a power of two, ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- lk_valid  in  1  fetch requests a table read this cycle.
- lk_idx  in  IDX_W  lookup index.
- lk_grant  out  1  lookup owns the table port this cycle (read data appears per table timing).
- upd_valid  in  1  EX stage presents a resolved-branch update.
- upd_idx  in  IDX_W  update index.
- upd_data  in  DATA_W  new entry value.
- upd_ready  out  1  update accepted when upd_valid && upd_ready.
- flush_req  in  1  one-cycle pulse; re-initialize the tables.
- busy  out  1  sweep in progress; the pipeline stalls fetch.
- tbl_en  out  1  table port enable.
- tbl_we  out  1  table write enable.
- tbl_addr  out  IDX_W  table address.
- tbl_wdata  out  DATA_W  table write data.
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- **Reset:** while reset is high: state=INIT, sweep ptr=0, FIFO empty, q_count=0, busy=1, upd_ready=0, lk_grant=0, tbl_en=tbl_we=0.
- **Outputs:** the tbl_* outputs, lk_grant and upd_ready are combinational from state, FIFO and inputs.
- **INIT state:**
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=ptr, tbl_wdata=INIT_VAL; ptr increments.
  - The first write is at index 0 in the first cycle after reset falls.
  - After the write at N-1, ptr wraps to 0 and the next cycle is RUN. A sweep takes exactly N cycles.
  - busy=1 and upd_ready=0 throughout; lk_valid and upd_valid are ignored.
- **RUN state, port priority per cycle (highest first):**
  1. FIFO full (q_count==DEPTH): write the FIFO head, pop; lk_grant=0. This prevents update starvation; fetch stalls on !lk_grant.
  2. lk_valid: tbl_en=1, tbl_we=0, tbl_addr=lk_idx, lk_grant=1.
  3. FIFO non-empty: write the head (tbl_we=1, addr/data from head), pop.
  4. FIFO empty and upd_valid: bypass; write upd_idx/upd_data directly this cycle, no enqueue.
  5. Otherwise tbl_en=0.
- **Update acceptance:**
  - upd_ready = (state==RUN) && (q_count<DEPTH).
  - An accepted update not bypassed is pushed at the tail.
  - Push and pop in the same cycle leave q_count unchanged. The pushed entry never pops in the same cycle it is pushed unless it is a bypass.
- **Ordering:** updates reach the table strictly in acceptance order. Duplicate indices are not coalesced; the later write wins.
- **Stale reads:** lookups to an index with a queued update read the stale value. This is architecturally acceptable (speculative predictor); no forwarding.
- **Flush:**
  - flush_req in RUN: FIFO cleared (q_count=0 next cycle), go to INIT with ptr=0. The current cycle's port action still completes.
  - flush_req in INIT: ptr restarts at 0.
  - An upd_valid coincident with flush_req is dropped.
- **Reset mid-sweep or mid-drain:** full reinitialization as above, with the sweep restarting at 0.
- **Pointers:** FIFO rd/wr pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; q_count is the full/empty authority.

Test Plan:
1. Reset sweep: IDX_W=4, reset pulses 2 cycles -> 16 consecutive writes addr 0..15, wdata=2'b01, busy=1 for exactly 16 cycles, then busy=0, upd_ready=1.
2. Bypass: RUN, empty FIFO, lk_valid=0, upd idx=5 data=2'b11 -> same cycle tbl_we=1, tbl_addr=5, tbl_wdata=2'b11, q_count stays 0.
3. Lookup priority: lk_valid idx=9 and upd idx=3 data=2'b10 together -> read addr 9 with lk_grant=1, q_count=1. Next cycle with no lookup -> write addr 3 data 2'b10, q_count=0.
4. Full/starvation: DEPTH=4, lk_valid held high, 4 updates idx 1..4 -> q_count=4, upd_ready=0. Next cycle lk_grant=0 and write idx 1, q_count=3. Following cycle lk_grant=1.
5. Flush: 3 updates queued, flush_req pulse -> q_count=0 next cycle, busy=1, sweep restarts at addr 0; queued updates are never written.
6. Reset mid-sweep: reset asserted when ptr=7 -> after release the first write is at addr 0 and the sweep lasts the full 16 cycles.
